// File: rtl/bus_if_if.sv
// Bundle of the core request side and the external 6502-style bus side of bus_if.
// master = core plus external device (the environment); slave = the bus_if sequencer.
interface bus_if_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [ADDR_W-1:0] ext_addr;
    logic              ext_rw;
    logic [7:0]        ext_dout;
    logic [7:0]        ext_din;
    logic              ext_rdy;
    logic              busy;
    logic [7:0]        rd_data;
    logic              rd_latch;
    logic              done;
    logic              err;

    modport master (
        output req, we, addr, wdata, ext_din, ext_rdy,
        input  ext_addr, ext_rw, ext_dout, busy, rd_data, rd_latch, done, err
    );

    modport slave (
        input  req, we, addr, wdata, ext_din, ext_rdy,
        output ext_addr, ext_rw, ext_dout, busy, rd_data, rd_latch, done, err
    );
endinterface

// File: rtl/bus_if.sv
// bus_if: external bus cycle sequencer IDLE -> ADDR -> DATA -> FIN with read capture.
// Define BUS_IF_RDY_EN to enable ext_rdy wait states and the TIMEOUT abort on reads.
module bus_if #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    bus_if_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } state_t;

    // The wait counter is 8 bits wide, so a larger timeout could never be reached.
    if (TIMEOUT < 0 || TIMEOUT > 255) begin : g_timeout_range
        $error("bus_if: TIMEOUT must fit the 8-bit wait counter");
    end

    state_t            state;
    state_t            state_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rd_data_q;
    logic              accept;
    logic              capture;
    logic              err_q;

`ifdef BUS_IF_RDY_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [7:0] wait_cnt;
    logic       abort;
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
`ifdef BUS_IF_RDY_EN
        abort    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept   = 1'b1;
                    state_nx = ADDR;
                end
            end
            ADDR: state_nx = DATA;
            DATA: begin
                if (we_q) begin
                    state_nx = FIN;
`ifdef BUS_IF_RDY_EN
                end else if (bus.ext_rdy) begin
                    // Ready is checked before the timeout so a late ready still completes.
                    capture  = 1'b1;
                    state_nx = FIN;
                end else if (TIMEOUT != 0 && wait_cnt == TMO) begin
                    abort    = 1'b1;
                    state_nx = FIN;
                end
`else
                end else begin
                    capture  = 1'b1;
                    state_nx = FIN;
                end
`endif
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (capture) begin
                rd_data_q <= bus.ext_din;
            end
        end
    end

`ifdef BUS_IF_RDY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == DATA && state_nx == DATA) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // err persists through IDLE until the next cycle is accepted.
            if (accept) begin
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.busy     = (state != IDLE);
    assign bus.ext_rw   = (state == ADDR || state == DATA) ? ~we_q : 1'b1;
    assign bus.ext_addr = addr_q;
    assign bus.ext_dout = wdata_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.done     = (state == FIN);
    assign bus.rd_latch = (state == FIN) && !we_q && !err_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_bus_if.sv
// Directed testbench for bus_if: driver pushes expected completions, a negedge monitor checks them.
// Expectations follow the BUS_IF_RDY_EN setting the design is compiled with.
module tb_bus_if;
    localparam int unsigned TMO = 15;

    typedef struct {
        logic        latch;
        logic        err;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    logic [7:0]  last_rd = 8'h00;
    exp_t        q[$];
    exp_t        me;

    bus_if_if #(.ADDR_W(16)) bif ();

    bus_if #(.ADDR_W(16), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},     32'(bif.busy),     32'd0);
        chk({tag, "_ext_rw"},   32'(bif.ext_rw),   32'd1);
        chk({tag, "_ext_addr"}, 32'(bif.ext_addr), 32'd0);
        chk({tag, "_ext_dout"}, 32'(bif.ext_dout), 32'd0);
        chk({tag, "_rd_data"},  32'(bif.rd_data),  32'd0);
        chk({tag, "_rd_latch"}, 32'(bif.rd_latch), 32'd0);
        chk({tag, "_done"},     32'(bif.done),     32'd0);
        chk({tag, "_err"},      32'(bif.err),      32'd0);
    endtask

    // Scoreboard monitor: every done pops one expected completion.
    always @(negedge clk) begin
        if (bif.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(bif.done), 32'd0);
            end else begin
                me = q.pop_front();
                chk("done_cycle", cyc, me.cyc);
                chk("rd_latch",   32'(bif.rd_latch), 32'(me.latch));
                chk("err",        32'(bif.err),      32'(me.err));
                chk("rd_data",    32'(bif.rd_data),  32'(me.data));
                chk("fin_ext_rw", 32'(bif.ext_rw),   32'd1);
            end
        end else if (bif.rd_latch) begin
            chk("stray_rd_latch", 32'(bif.rd_latch), 32'd0);
        end
    end

    // Called at an IDLE negedge; returns at a negedge with the DUT idle again.
    task automatic run_cycle(input logic w, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] din_final, input int unsigned low, input bit stuck);
        exp_t        e;
        int unsigned n0;
        bit          rdy0;
        chk("idle_before_req", 32'(bif.busy), 32'd0);
        rdy0 = (low == 0) && !stuck;
        bif.req     = 1'b1;
        bif.we      = w;
        bif.addr    = a;
        bif.wdata   = d;
        bif.ext_rdy = rdy0;
        bif.ext_din = rdy0 ? din_final : 8'hEE;
        n0 = cyc;
        e.err   = 1'b0;
        e.latch = !w;
        e.data  = last_rd;
        e.cyc   = n0 + 3;
        if (!w) begin
`ifdef BUS_IF_RDY_EN
            if (stuck) begin
                e.latch = 1'b0;
                e.err   = 1'b1;
                e.cyc   = n0 + 3 + TMO;
            end else begin
                e.data = din_final;
                e.cyc  = n0 + 3 + low;
            end
`else
            e.data = rdy0 ? din_final : 8'hEE;
`endif
        end
        if (e.latch) last_rd = e.data;
        q.push_back(e);
        @(negedge clk);
        bif.req = 1'b0;
        chk("addr_busy",     32'(bif.busy),     32'd1);
        chk("addr_ext_rw",   32'(bif.ext_rw),   32'(!w));
        chk("addr_ext_addr", 32'(bif.ext_addr), 32'(a));
        chk("addr_err_clr",  32'(bif.err),      32'd0);
        if (w) chk("addr_ext_dout", 32'(bif.ext_dout), 32'(d));
        @(negedge clk);
        chk("data_ext_rw",   32'(bif.ext_rw),   32'(!w));
        if (!stuck && low > 0) begin
            repeat (low) @(negedge clk);
            bif.ext_rdy = 1'b1;
            bif.ext_din = din_final;
        end
        for (int i = 0; i < 40 && bif.busy; i++) @(negedge clk);
        chk("cycle_ends", 32'(bif.busy), 32'd0);
        bif.ext_rdy = 1'b1;
    endtask

    initial begin
        int unsigned n0;
        exp_t        e;
        bif.req = 1'b0; bif.we = 1'b0; bif.addr = '0; bif.wdata = '0;
        bif.ext_din = 8'h00; bif.ext_rdy = 1'b1;
        #1;
        chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait read.
        run_cycle(1'b0, 16'h1234, 8'h00, 8'hA5, 0, 1'b0);
        // Read with ext_rdy stuck low: timeout abort when enabled.
        run_cycle(1'b0, 16'h2000, 8'h00, 8'hEE, 0, 1'b1);
`ifdef BUS_IF_RDY_EN
        chk("err_hold_idle", 32'(bif.err), 32'd1);
        @(negedge clk);
        chk("err_hold_idle2", 32'(bif.err), 32'd1);
`endif
        // Write with ext_rdy low: ready must be ignored.
        run_cycle(1'b1, 16'h0200, 8'h3C, 8'h00, 0, 1'b1);
        // Read with three wait states.
        run_cycle(1'b0, 16'h3456, 8'h00, 8'h5A, 3, 1'b0);
        // Ready rises in the cycle the counter hits TIMEOUT.
        run_cycle(1'b0, 16'hFFFF, 8'h00, 8'hC3, TMO, 1'b0);

        // req held high: one accept per 4 cycles, the rest dropped.
        bif.req = 1'b1; bif.we = 1'b0; bif.addr = 16'h4000;
        bif.ext_rdy = 1'b1; bif.ext_din = 8'h77;
        n0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.latch = 1'b1; e.err = 1'b0; e.data = 8'h77; e.cyc = n0 + 3 + 4 * k;
            q.push_back(e);
        end
        last_rd = 8'h77;
        repeat (4) @(negedge clk);
        chk("b2b_idle_gap", 32'(bif.busy), 32'd0);
        @(negedge clk);
        chk("b2b_reaccept", 32'(bif.busy), 32'd1);
        repeat (5) @(negedge clk);
        bif.req = 1'b0;
        for (int i = 0; i < 20 && bif.busy; i++) @(negedge clk);
        chk("b2b_ends", 32'(bif.busy), 32'd0);

        // Reset asserted during DATA: cycle abandoned, no done.
        bif.req = 1'b1; bif.we = 1'b0; bif.addr = 16'h0BAD; bif.ext_din = 8'h99;
        @(negedge clk);
        bif.req = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(bif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        last_rd = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_cycle(1'b0, 16'h1234, 8'h00, 8'hA5, 0, 1'b0);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
